// File: rtl/dct_arbiter.sv
// dct_arbiter
//   Round-robin arbiter sharing one 1-D DCT core among n_req requesters.
//   Winning requester vectors go to the core through a registered issue stage.
//   Each issued vector's requester index is queued in a tag FIFO. Core results
//   are routed back to requesters in issue order.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   req_i_*        per-requester request vectors/valids, req_o_ready grant
//   rsp_o_*        result data (broadcast) and per-requester result valid,
//                  rsp_i_ready per-requester result ready
//   dct_o_*        issue stage towards core input, dct_i_ready from core
//   dct_i_*        core result stream, dct_o_ready back to core
//   err            sticky: a core result arrived with no outstanding tag
//   inflight       tag FIFO occupancy
module dct_arbiter #(
    parameter int unsigned data_width = 256,
    parameter int unsigned n_req      = 2,
    parameter int unsigned tag_depth  = 4,
    localparam int unsigned tag_w     = (n_req > 1) ? $clog2(n_req) : 1,
    localparam int unsigned cnt_w     = $clog2(tag_depth + 1)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [n_req*data_width-1:0] req_i_data,
    input  logic [n_req-1:0]            req_i_valid,
    output logic [n_req-1:0]            req_o_ready,
    output logic [data_width-1:0]       rsp_o_data,
    output logic [n_req-1:0]            rsp_o_valid,
    input  logic [n_req-1:0]            rsp_i_ready,
    output logic [data_width-1:0]       dct_o_data,
    output logic                        dct_o_valid,
    input  logic                        dct_i_ready,
    input  logic [data_width-1:0]       dct_i_data,
    input  logic                        dct_i_valid,
    output logic                        dct_o_ready,
    output logic                        err,
    output logic [cnt_w-1:0]            inflight
);

    localparam int unsigned ptr_w = (tag_depth > 1) ? $clog2(tag_depth) : 1;

    logic                  dct_o_valid_q, dct_o_valid_d;
    logic [data_width-1:0] dct_o_data_q, dct_o_data_d;
    logic [tag_w-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  err_q, err_d;
    logic [cnt_w-1:0]      cnt_q, cnt_d;
    logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [tag_w-1:0]      tag_mem_q [tag_depth];
    logic [tag_w-1:0]      tag_mem_d [tag_depth];

    logic                  can_issue;
    logic                  found;
    logic [tag_w-1:0]      win;
    logic [tag_w-1:0]      sel;
    int unsigned           idx;
    logic                  push, pop, empty;
    logic [tag_w-1:0]      head;

    // Round-robin search starting at rr_ptr
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            idx = (int'(rr_ptr_q) + i) % n_req;
            sel = tag_w'(idx);
            if (!found && req_i_valid[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    // A full FIFO blocks issue even when a pop happens in the same cycle
    assign can_issue = (!dct_o_valid_q || dct_i_ready) && (cnt_q < cnt_w'(tag_depth));
    assign push      = can_issue && found;

    always_comb begin
        req_o_ready = '0;
        if (push) req_o_ready[win] = 1'b1;
    end

    // Response routing from FIFO head; an empty FIFO drains stray results
    assign empty = (cnt_q == '0);
    assign head  = tag_mem_q[rd_ptr_q];

    always_comb begin
        rsp_o_valid = '0;
        dct_o_ready = 1'b1;
        if (!empty) begin
            rsp_o_valid[head] = dct_i_valid;
            dct_o_ready       = rsp_i_ready[head];
        end
    end

    assign pop        = !empty && dct_i_valid && dct_o_ready;
    assign rsp_o_data = dct_i_data;

    always_comb begin
        dct_o_valid_d = dct_o_valid_q;
        dct_o_data_d  = dct_o_data_q;
        rr_ptr_d      = rr_ptr_q;
        err_d         = err_q | (empty && dct_i_valid);
        cnt_d         = cnt_q + cnt_w'(push) - cnt_w'(pop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_mem_d     = tag_mem_q;
        if (push) begin
            dct_o_valid_d       = 1'b1;
            dct_o_data_d        = req_i_data[int'(win)*data_width +: data_width];
            rr_ptr_d            = (win == tag_w'(n_req - 1)) ? '0 : win + 1'b1;
            tag_mem_d[wr_ptr_q] = win;
            wr_ptr_d            = (wr_ptr_q == ptr_w'(tag_depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end else if (dct_o_valid_q && dct_i_ready) begin
            dct_o_valid_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == ptr_w'(tag_depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dct_o_valid_q <= 1'b0;
            dct_o_data_q  <= '0;
            rr_ptr_q      <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int unsigned i = 0; i < tag_depth; i++) tag_mem_q[i] <= '0;
        end else begin
            dct_o_valid_q <= dct_o_valid_d;
            dct_o_data_q  <= dct_o_data_d;
            rr_ptr_q      <= rr_ptr_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_mem_q     <= tag_mem_d;
        end
    end

    assign dct_o_valid = dct_o_valid_q;
    assign dct_o_data  = dct_o_data_q;
    assign err         = err_q;
    assign inflight    = cnt_q;

endmodule

// File: tb/tb_dct_arbiter.sv
module tb_dct_arbiter;

    localparam int unsigned DW = 256;

    logic           clk = 1'b0;
    logic           rstn;
    logic [DW-1:0]  d0, d1;
    logic [2*DW-1:0] req_i_data;
    logic [1:0]     req_i_valid, req_o_ready, rsp_o_valid, rsp_i_ready;
    logic [DW-1:0]  rsp_o_data, dct_o_data, dct_i_data;
    logic           dct_o_valid, dct_i_ready, dct_i_valid, dct_o_ready, err;
    logic [2:0]     inflight;

    int nvec = 0;
    int nerr = 0;

    assign req_i_data = {d1, d0};

    dct_arbiter #(.data_width(256), .n_req(2), .tag_depth(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_i_data(req_i_data), .req_i_valid(req_i_valid), .req_o_ready(req_o_ready),
        .rsp_o_data(rsp_o_data), .rsp_o_valid(rsp_o_valid), .rsp_i_ready(rsp_i_ready),
        .dct_o_data(dct_o_data), .dct_o_valid(dct_o_valid), .dct_i_ready(dct_i_ready),
        .dct_i_data(dct_i_data), .dct_i_valid(dct_i_valid), .dct_o_ready(dct_o_ready),
        .err(err), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1; d0 = '0; d1 = '0; req_i_valid = '0; rsp_i_ready = '0;
        dct_i_ready = 1'b0; dct_i_data = '0; dct_i_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        // reset state, combinational outputs evaluated in reset
        check("rst_valid", dct_o_valid, 0);
        check("rst_data", dct_o_data, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", err, 0);
        check("rst_dct_o_ready", dct_o_ready, 1);
        check("rst_rsp_valid", rsp_o_valid, 0);
        req_i_valid = 2'b10; #1;
        check("rst_grant_hi", req_o_ready, 2'b10);
        req_i_valid = 2'b11; #1;
        check("rst_grant_lo", req_o_ready, 2'b01);
        req_i_valid = 2'b00;
        tick(); tick();
        rstn = 1'b1;

        // single requester
        d0 = 256'h01; req_i_valid = 2'b01; dct_i_ready = 1'b1; rsp_i_ready = 2'b11; #1;
        check("single_ready", req_o_ready, 2'b01);
        tick();
        req_i_valid = 2'b00;
        check("single_valid", dct_o_valid, 1);
        check("single_data", dct_o_data, 256'h01);
        check("single_inflight1", inflight, 1);
        tick();
        check("single_accepted", dct_o_valid, 0);
        dct_i_valid = 1'b1; dct_i_data = 256'hA5A5; #1;
        check("single_rsp_valid", rsp_o_valid, 2'b01);
        check("single_rsp_data", rsp_o_data, 256'hA5A5);
        check("single_dct_o_ready", dct_o_ready, 1);
        tick();
        dct_i_valid = 1'b0;
        check("single_inflight0", inflight, 0);

        // stray result with empty FIFO
        dct_i_valid = 1'b1; #1;
        check("stray_rsp_valid", rsp_o_valid, 2'b00);
        check("stray_drain", dct_o_ready, 1);
        check("stray_err_before", err, 0);
        tick();
        dct_i_valid = 1'b0;
        check("err_set", err, 1);
        tick();
        check("err_sticky", err, 1);

        // contention: rr_ptr is 1 after the single grant to 0; fill FIFO to 4
        d0 = 256'h10; d1 = 256'h20; req_i_valid = 2'b11; #1;
        check("cont_g0", req_o_ready, 2'b10);
        tick();
        check("cont_d0", dct_o_data, 256'h20);
        check("cont_g1", req_o_ready, 2'b01);
        tick();
        check("cont_d1", dct_o_data, 256'h10);
        check("cont_g2", req_o_ready, 2'b10);
        tick();
        check("cont_d2", dct_o_data, 256'h20);
        check("cont_g3", req_o_ready, 2'b01);
        tick();
        check("cont_d3", dct_o_data, 256'h10);
        check("full_inflight", inflight, 4);
        check("full_blocks", req_o_ready, 2'b00);
        tick();
        check("full_valid_clr", dct_o_valid, 0);
        check("full_still", req_o_ready, 2'b00);

        // head tag 1 with requester 1 not ready
        dct_i_valid = 1'b1; dct_i_data = 256'hB1; rsp_i_ready = 2'b01; #1;
        check("bp_rsp_valid", rsp_o_valid, 2'b10);
        check("bp_dct_o_ready", dct_o_ready, 0);
        tick();
        check("bp_inflight", inflight, 4);
        check("bp_held", rsp_o_valid, 2'b10);
        rsp_i_ready = 2'b11; #1;
        check("pop_ready", dct_o_ready, 1);
        check("full_pop_blocks", req_o_ready, 2'b00);
        tick();
        check("after_pop", inflight, 3);
        check("after_pop_grant", req_o_ready, 2'b10);
        dct_i_data = 256'hB2; #1;
        check("rsp2_valid", rsp_o_valid, 2'b01);
        check("rsp2_data", rsp_o_data, 256'hB2);
        tick();
        check("pushpop_inflight", inflight, 3);
        check("pushpop_data", dct_o_data, 256'h20);
        dct_i_valid = 1'b0; dct_i_ready = 1'b0; #1;

        // core backpressure
        for (int i = 0; i < 5; i++) begin
            check("cbp_valid", dct_o_valid, 1);
            check("cbp_data", dct_o_data, 256'h20);
            check("cbp_ready", req_o_ready, 2'b00);
            tick();
        end
        dct_i_ready = 1'b1; #1;
        check("cbp_release", req_o_ready, 2'b01);
        tick();
        req_i_valid = 2'b00;
        check("cbp_data2", dct_o_data, 256'h10);
        check("cbp_inflight", inflight, 4);
        dct_i_valid = 1'b1; dct_i_data = 256'hB3; #1;
        check("rsp3_valid", rsp_o_valid, 2'b10);
        tick();
        dct_i_valid = 1'b0;
        check("pre_rst_inflight", inflight, 3);

        // asynchronous reset mid-stream
        rstn = 1'b0; #1;
        check("arst_valid", dct_o_valid, 0);
        check("arst_data", dct_o_data, 0);
        check("arst_inflight", inflight, 0);
        check("arst_err", err, 0);
        check("arst_dct_o_ready", dct_o_ready, 1);
        tick();
        rstn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dct_arbiter.md
# dct_arbiter

Round-robin arbiter that shares one 1-D `dct` core between `n_req` requesters, such as several block-level DCT sequencers. It accepts row/column vectors over valid/ready handshakes and forwards them to the core through a registered output stage. It tags each issued vector with its requester index and routes each core result back to the requester that issued it, in issue order.

## Interface
- `data_width`, default 256: width of one vector (8 × 32-bit samples).
- `n_req`, default 2: number of requesters; legal range 2..8.
- `tag_depth`, default 4: maximum number of vectors in flight inside the core; legal range 1..16.
- Derived: `tag_w` = max(1, clog2(`n_req`)).

Ports:
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `req_i_data`  in  `n_req`·`data_width`  requester k vector in slice [k·`data_width` +: `data_width`].
- `req_i_valid`  in  `n_req`  per-requester valid.
- `req_o_ready`  out  `n_req`  per-requester ready (one-hot or zero).
- `rsp_o_data`  out  `data_width`  result data, broadcast to all requesters.
- `rsp_o_valid`  out  `n_req`  per-requester result valid (one-hot or zero).
- `rsp_i_ready`  in  `n_req`  per-requester result ready.
- `dct_o_data`  out  `data_width`  vector to core `i_data`.
- `dct_o_valid`  out  1  to core `i_valid`.
- `dct_i_ready`  in  1  from core `o_ready`.
- `dct_i_data`  in  `data_width`  from core `o_data`.
- `dct_i_valid`  in  1  from core `o_valid`.
- `dct_o_ready`  out  1  to core `i_ready`.
- `err`  out  1  sticky: core produced a result with no outstanding tag.
- `inflight`  out  clog2(`tag_depth`+1)  current tag FIFO occupancy.

## Operation
- Issue register (`dct_o_data`/`dct_o_valid`) is free when `dct_o_valid`=0, or when `dct_o_valid`=1 and `dct_i_ready`=1 in the same cycle.
- `can_issue` = issue register free AND `inflight` < `tag_depth`. A full tag FIFO blocks issue even if a pop occurs in the same cycle.
- Winner: first k with `req_i_valid`[k]=1, searching from `rr_ptr` upward modulo `n_req`.
- `req_o_ready`[winner]=1 only when `can_issue`; all other bits are 0. This output is combinational from `req_i_valid`, `rr_ptr` and the state.
- Grant handshake (`req_i_valid`[k] && `req_o_ready`[k]), all effects on the next edge:
  - capture the slice into `dct_o_data` and set `dct_o_valid`=1;
  - push tag k into the tag FIFO;
  - set `rr_ptr` = (k+1) mod `n_req`.
- If no grant occurs and the core accepted (`dct_o_valid` && `dct_i_ready`), clear `dct_o_valid`. `dct_o_data` holds its value.
- `dct_o_data` and `dct_o_valid` stay stable while `dct_o_valid`=1 and `dct_i_ready`=0.
- Response path, FIFO non-empty with head tag t:
  - `rsp_o_valid`[t] = `dct_i_valid`; all other bits are 0.
  - `dct_o_ready` = `rsp_i_ready`[t].
  - `rsp_o_data` = `dct_i_data`, a combinational pass-through.
- Pop the head on `dct_i_valid` && `dct_o_ready`.
- FIFO empty:
  - `rsp_o_valid`=0 and `dct_o_ready`=1, so stray results are drained.
  - If `dct_i_valid`=1 in this state, set `err`=1 on the next edge; it is cleared only by reset.
- Push and pop in the same cycle leave `inflight` unchanged. Tag FIFO pointers wrap modulo `tag_depth`.
- Requesters must hold data stable while valid and not granted. The arbiter does not check this.

## Timing
- Reset (`rstn`=0, asynchronous): `dct_o_valid`=0, `dct_o_data`=0, `rr_ptr`=0, FIFO empty, `inflight`=0, `err`=0.
  - During reset, combinational outputs evaluate with the reset state: `req_o_ready` = grant to the lowest valid index, `rsp_o_valid`=0, `dct_o_ready`=1.
- Reset asserted mid-operation discards all in-flight tags. Results the core emits after reset are drained and flag `err`; integration must reset the core together with the arbiter.
- Grant to `dct_o_valid`: 1 cycle.
- Sustained throughput: 1 vector per cycle while `dct_i_ready`=1, `inflight` < `tag_depth`, and results drain.
- Result to requester: 0 cycles (combinational).
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,`n_req`−1,0,…; no requester waits more than `n_req`−1 grants.

## Test plan
- Single requester: requester 0 sends A=0x…01; core returns R after latency → `dct_o_data`=A one cycle after grant; `rsp_o_valid`=2'b01 with `rsp_o_data`=R; `inflight` goes 0→1→0.
- Contention: `n_req`=2, both valid continuously for 6 grants → grant order 0,1,0,1,0,1; responses return to requesters 0,1,0,1,0,1 in order.
- Core backpressure: `dct_i_ready`=0 for 5 cycles with `dct_o_valid`=1 → `dct_o_data` stable, `req_o_ready`=0; first grant occurs in the cycle `dct_i_ready` rises.
- Tag full: `tag_depth`=2, core never returns → exactly 2 grants, then `req_o_ready`=0 and `inflight`=2; after one result pops, the next grant issues on the following cycle.
- Response backpressure: head tag 1 with `rsp_i_ready`[1]=0 → `dct_o_ready`=0 and result held; `rsp_i_ready`[0]=1 has no effect.
- Error/reset: `dct_i_valid`=1 with FIFO empty → `err`=1 next cycle; assert `rstn`=0 mid-stream with `inflight`=3 → outputs return to reset values immediately, `err`=0.
